// File: rtl/mips_mem_stage_lsu_if.sv
`default_nettype none
// ============================================================================
//  Module      : mips_mem_stage_lsu_if
//  Description : Data-memory request/acknowledge bus with byte lanes, shared
//                by the MEM-stage load/store unit (master) and the memory
//                side (slave).
//  Revision    : 1.0 - initial release
// ============================================================================
interface mips_mem_stage_lsu_if #(
   parameter int WORD_W = 32,
   parameter int BE_W   = WORD_W / 8
);
   logic              dmem_req;
   logic              dmem_we;
   logic [WORD_W-1:0] dmem_addr;
   logic [BE_W-1:0]   dmem_be;
   logic [WORD_W-1:0] dmem_wdata;
   logic              dmem_ack;
   logic [WORD_W-1:0] dmem_rdata;

   modport master (
      output dmem_req,
      output dmem_we,
      output dmem_addr,
      output dmem_be,
      output dmem_wdata,
      input  dmem_ack,
      input  dmem_rdata
   );

   modport slave (
      input  dmem_req,
      input  dmem_we,
      input  dmem_addr,
      input  dmem_be,
      input  dmem_wdata,
      output dmem_ack,
      output dmem_rdata
   );
endinterface
`default_nettype wire

// File: rtl/mips_mem_stage_lsu.sv
`default_nettype none
// ============================================================================
//  Module      : mips_mem_stage_lsu
//  Description : MEM-stage load/store unit. Issues one req/ack data-memory
//                transaction per load/store, stalls IF..MEM while it is open,
//                and returns the aligned, sign/zero-extended load result.
//  Revision    : 1.0 - initial release
// ============================================================================
module mips_mem_stage_lsu #(
   parameter int WORD_W = 32,
   parameter int BE_W   = WORD_W / 8
) (
   input  wire                  clock,
   input  wire                  reset_n,
   input  wire                  pipeMem_Valid,
   input  wire                  pipeMem_MemRead,
   input  wire                  pipeMem_MemWrite,
   input  wire  [1:0]           pipeMem_MemSize,
   input  wire                  pipeMem_MemSigned,
   input  wire  [WORD_W-1:0]    pipeMem_MemAddr,
   input  wire  [WORD_W-1:0]    memData,
   input  wire                  pipeHold,
   input  wire                  flush,
   mips_mem_stage_lsu_if.master dmem,
   output logic [WORD_W-1:0]    loadData,
   output logic                 loadValid,
   output logic                 memStall,
   output logic                 addrError
);

   localparam logic [1:0] c_SIZE_BYTE = 2'd0;
   localparam logic [1:0] c_SIZE_HALF = 2'd1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t              r_state;
   state_t              w_state_next;

   logic                r_we;
   logic [WORD_W-1:0]   r_addr;
   logic [1:0]          r_lane;
   logic [1:0]          r_size;
   logic                r_signed;
   logic [BE_W-1:0]     r_be;
   logic [WORD_W-1:0]   r_wdata;
   logic                r_kill;
   logic [WORD_W-1:0]   r_load_data;

   logic                w_op;
   logic                w_is_byte;
   logic                w_is_half;
   logic                w_is_word;
   logic                w_misaligned;
   logic                w_accept;
   logic [BE_W-1:0]     w_be;
   logic [WORD_W-1:0]   w_wdata;
   logic [7:0]          w_ld_byte;
   logic [15:0]         w_ld_half;
   logic [WORD_W-1:0]   w_load_ext;

   // A flushed instruction is never accepted; size 3 falls through to word.
   assign w_op         = pipeMem_Valid & (pipeMem_MemRead | pipeMem_MemWrite) & ~flush;
   assign w_is_byte    = (pipeMem_MemSize == c_SIZE_BYTE);
   assign w_is_half    = (pipeMem_MemSize == c_SIZE_HALF);
   assign w_is_word    = pipeMem_MemSize[1];
   assign w_misaligned = (w_is_half & pipeMem_MemAddr[0]) |
                         (w_is_word & (pipeMem_MemAddr[1:0] != 2'b00));

   // Byte enables and lane-replicated store data for the incoming access.
   always_comb begin
      w_be    = '1;
      w_wdata = memData;
      if (w_is_byte) begin
         w_be    = BE_W'(1) << pipeMem_MemAddr[1:0];
         w_wdata = {4{memData[7:0]}};
      end else if (w_is_half) begin
         w_be    = pipeMem_MemAddr[1] ? 4'b1100 : 4'b0011;
         w_wdata = {2{memData[15:0]}};
      end
   end

   // Pick the addressed byte/half from the read word and extend it.
   always_comb begin
      case (r_lane)
         2'd0:    w_ld_byte = dmem.dmem_rdata[7:0];
         2'd1:    w_ld_byte = dmem.dmem_rdata[15:8];
         2'd2:    w_ld_byte = dmem.dmem_rdata[23:16];
         default: w_ld_byte = dmem.dmem_rdata[31:24];
      endcase
      w_ld_half  = r_lane[1] ? dmem.dmem_rdata[31:16] : dmem.dmem_rdata[15:0];
      w_load_ext = dmem.dmem_rdata;
      if (r_size == c_SIZE_BYTE) begin
         w_load_ext = {{24{r_signed & w_ld_byte[7]}}, w_ld_byte};
      end else if (r_size == c_SIZE_HALF) begin
         w_load_ext = {{16{r_signed & w_ld_half[15]}}, w_ld_half};
      end
   end

   // State register; asynchronous reset drops the bus request immediately.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next-state and pipeline control outputs.
   always_comb begin
      w_state_next = r_state;
      w_accept     = 1'b0;
      memStall     = 1'b0;
      addrError    = 1'b0;
      loadValid    = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_op) begin
               if (w_misaligned) begin
                  addrError = 1'b1;
               end else begin
                  memStall     = 1'b1;
                  w_accept     = 1'b1;
                  w_state_next = S_REQ;
               end
            end
         end
         S_REQ: begin
            memStall = 1'b1;
            if (dmem.dmem_ack) begin
               // A killed access finishes on the bus but never retires.
               w_state_next = (r_kill | flush) ? S_IDLE : S_DONE;
            end
         end
         S_DONE: begin
            loadValid = ~r_we & ~flush;
            if (!pipeHold) begin
               w_state_next = S_IDLE;
            end
         end
         default: begin
            w_state_next = S_IDLE;
         end
      endcase
      if (!reset_n) begin
         memStall  = 1'b0;
         addrError = 1'b0;
         loadValid = 1'b0;
      end
   end

   // Request fields are captured on acceptance and held until the ack.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_we        <= 1'b0;
         r_addr      <= '0;
         r_lane      <= 2'd0;
         r_size      <= 2'd0;
         r_signed    <= 1'b0;
         r_be        <= '0;
         r_wdata     <= '0;
         r_kill      <= 1'b0;
         r_load_data <= '0;
      end else begin
         if (w_accept) begin
            r_we     <= pipeMem_MemWrite;
            r_addr   <= {pipeMem_MemAddr[WORD_W-1:2], 2'b00};
            r_lane   <= pipeMem_MemAddr[1:0];
            r_size   <= pipeMem_MemSize;
            r_signed <= pipeMem_MemSigned;
            r_be     <= w_be;
            r_wdata  <= w_wdata;
            r_kill   <= 1'b0;
         end else if ((r_state == S_REQ) && flush) begin
            r_kill <= 1'b1;
         end
         if ((r_state == S_REQ) && dmem.dmem_ack && !r_we) begin
            r_load_data <= w_load_ext;
         end
      end
   end

   assign dmem.dmem_req   = (r_state == S_REQ);
   assign dmem.dmem_we    = r_we;
   assign dmem.dmem_addr  = r_addr;
   assign dmem.dmem_be    = r_be;
   assign dmem.dmem_wdata = r_wdata;
   assign loadData        = r_load_data;

endmodule
`default_nettype wire

// File: tb/tb_mips_mem_stage_lsu.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mips_mem_stage_lsu
//  Description : Directed self-checking bench for mips_mem_stage_lsu.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mips_mem_stage_lsu;

   logic        clock;
   logic        reset_n;
   logic        pipeMem_Valid;
   logic        pipeMem_MemRead;
   logic        pipeMem_MemWrite;
   logic [1:0]  pipeMem_MemSize;
   logic        pipeMem_MemSigned;
   logic [31:0] pipeMem_MemAddr;
   logic [31:0] memData;
   logic        pipeHold;
   logic        flush;
   logic [31:0] loadData;
   logic        loadValid;
   logic        memStall;
   logic        addrError;

   int n_checks;
   int n_errors;

   int          obs_stalls;
   int          obs_lv;
   int          obs_reqs;
   logic [31:0] obs_ld;
   logic [31:0] obs_addr;
   logic [31:0] obs_wdata;
   logic [3:0]  obs_be;
   logic        obs_we;
   logic        obs_timeout;
   logic        obs_ld_stable;

   mips_mem_stage_lsu_if dif ();

   mips_mem_stage_lsu dut (
      .clock             (clock),
      .reset_n           (reset_n),
      .pipeMem_Valid     (pipeMem_Valid),
      .pipeMem_MemRead   (pipeMem_MemRead),
      .pipeMem_MemWrite  (pipeMem_MemWrite),
      .pipeMem_MemSize   (pipeMem_MemSize),
      .pipeMem_MemSigned (pipeMem_MemSigned),
      .pipeMem_MemAddr   (pipeMem_MemAddr),
      .memData           (memData),
      .pipeHold          (pipeHold),
      .flush             (flush),
      .dmem              (dif),
      .loadData          (loadData),
      .loadValid         (loadValid),
      .memStall          (memStall),
      .addrError         (addrError)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Drives one access from posedge+1 of an IDLE cycle, answers the bus
   // after ack_after REQ cycles and holds DONE for hold_n cycles.
   task automatic run_op(input logic wr, input logic [1:0] size, input logic sgn,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] rdata, input int ack_after, input int hold_n);
      int   hold_left;
      int   phase;
      logic finished;
      obs_stalls = 0; obs_lv = 0; obs_reqs = 0; obs_ld = '0;
      obs_timeout = 1'b0; obs_ld_stable = 1'b1;
      hold_left = hold_n; phase = 0; finished = 1'b0;
      pipeMem_Valid = 1'b1; pipeMem_MemRead = ~wr; pipeMem_MemWrite = wr;
      pipeMem_MemSize = size; pipeMem_MemSigned = sgn; pipeMem_MemAddr = addr;
      memData = wdata;
      for (int c = 0; c < 40 && !finished; c++) begin
         if (phase == 2) begin
            pipeMem_Valid = 1'b0; pipeMem_MemRead = 1'b0; pipeMem_MemWrite = 1'b0;
            pipeHold = 1'b0; dif.dmem_ack = 1'b0;
            finished = 1'b1;
         end else begin
            if (dif.dmem_req) begin
               obs_reqs++;
               obs_addr = dif.dmem_addr; obs_be = dif.dmem_be;
               obs_wdata = dif.dmem_wdata; obs_we = dif.dmem_we;
            end
            dif.dmem_ack   = dif.dmem_req && (obs_reqs == ack_after);
            dif.dmem_rdata = rdata;
            if (phase == 1) begin
               if (hold_left > 0) begin
                  pipeHold = 1'b1;
                  hold_left--;
               end else begin
                  pipeHold = 1'b0;
                  phase = 2;
               end
            end
            if (dif.dmem_ack) phase = 1;
            @(negedge clock);
            if (memStall) obs_stalls++;
            if (loadValid) begin
               if (obs_lv > 0 && loadData !== obs_ld) obs_ld_stable = 1'b0;
               obs_lv++;
               obs_ld = loadData;
            end
            @(posedge clock); #1;
         end
      end
      if (!finished) begin
         obs_timeout = 1'b1;
         pipeMem_Valid = 1'b0; pipeMem_MemRead = 1'b0; pipeMem_MemWrite = 1'b0;
         pipeHold = 1'b0; dif.dmem_ack = 1'b0;
      end
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      pipeMem_Valid = 1'b1; pipeMem_MemRead = 1'b1; pipeMem_MemSize = 2'd2;
      pipeMem_MemAddr = 32'h0000_0102;
      repeat (2) @(posedge clock);
      @(negedge clock);
      n_checks++; if (dif.dmem_req !== 1'b0) begin n_errors++; $display("FAIL reset_req: got %b want 0", dif.dmem_req); end
      n_checks++; if (dif.dmem_we !== 1'b0) begin n_errors++; $display("FAIL reset_we: got %b want 0", dif.dmem_we); end
      n_checks++; if (dif.dmem_addr !== 32'h0) begin n_errors++; $display("FAIL reset_addr: got %h want 0", dif.dmem_addr); end
      n_checks++; if (dif.dmem_be !== 4'h0) begin n_errors++; $display("FAIL reset_be: got %b want 0000", dif.dmem_be); end
      n_checks++; if (dif.dmem_wdata !== 32'h0) begin n_errors++; $display("FAIL reset_wdata: got %h want 0", dif.dmem_wdata); end
      n_checks++; if (loadData !== 32'h0) begin n_errors++; $display("FAIL reset_loadData: got %h want 0", loadData); end
      n_checks++; if (loadValid !== 1'b0) begin n_errors++; $display("FAIL reset_loadValid: got %b want 0", loadValid); end
      n_checks++; if (memStall !== 1'b0) begin n_errors++; $display("FAIL reset_memStall: got %b want 0", memStall); end
      n_checks++; if (addrError !== 1'b0) begin n_errors++; $display("FAIL reset_addrError: got %b want 0", addrError); end
      pipeMem_Valid = 1'b0; pipeMem_MemRead = 1'b0;
      @(posedge clock); #1;
      reset_n = 1'b1;
      @(posedge clock); #1;
   endtask

   task automatic test_lw_latency();
      run_op(1'b0, 2'd2, 1'b0, 32'h0000_0100, 32'h0, 32'hDEAD_BEEF, 3, 0);
      n_checks++; if (obs_timeout !== 1'b0) begin n_errors++; $display("FAIL lw_timeout: got %b want 0", obs_timeout); end
      n_checks++; if (obs_stalls != 4) begin n_errors++; $display("FAIL lw_stall_cycles: got %0d want 4", obs_stalls); end
      n_checks++; if (obs_lv != 1) begin n_errors++; $display("FAIL lw_loadValid_cycles: got %0d want 1", obs_lv); end
      n_checks++; if (obs_ld !== 32'hDEAD_BEEF) begin n_errors++; $display("FAIL lw_loadData: got %h want deadbeef", obs_ld); end
      n_checks++; if (obs_addr !== 32'h0000_0100) begin n_errors++; $display("FAIL lw_addr: got %h want 00000100", obs_addr); end
      n_checks++; if (obs_be !== 4'b1111) begin n_errors++; $display("FAIL lw_be: got %b want 1111", obs_be); end
      n_checks++; if (obs_we !== 1'b0) begin n_errors++; $display("FAIL lw_we: got %b want 0", obs_we); end
   endtask

   task automatic test_load_extend();
      run_op(1'b0, 2'd0, 1'b1, 32'h0000_0103, 32'h0, 32'h80FF_7F01, 1, 0);
      n_checks++; if (obs_ld !== 32'hFFFF_FF80) begin n_errors++; $display("FAIL lb_loadData: got %h want ffffff80", obs_ld); end
      n_checks++; if (obs_stalls != 2) begin n_errors++; $display("FAIL lb_min_stall: got %0d want 2", obs_stalls); end
      n_checks++; if (obs_be !== 4'b1000) begin n_errors++; $display("FAIL lb_be: got %b want 1000", obs_be); end
      n_checks++; if (obs_addr !== 32'h0000_0100) begin n_errors++; $display("FAIL lb_addr: got %h want 00000100", obs_addr); end
      run_op(1'b0, 2'd0, 1'b0, 32'h0000_0103, 32'h0, 32'h80FF_7F01, 1, 0);
      n_checks++; if (obs_ld !== 32'h0000_0080) begin n_errors++; $display("FAIL lbu_loadData: got %h want 00000080", obs_ld); end
      run_op(1'b0, 2'd1, 1'b1, 32'h0000_0102, 32'h0, 32'h80FF_7F01, 2, 0);
      n_checks++; if (obs_ld !== 32'hFFFF_80FF) begin n_errors++; $display("FAIL lh_loadData: got %h want ffff80ff", obs_ld); end
      n_checks++; if (obs_be !== 4'b1100) begin n_errors++; $display("FAIL lh_be: got %b want 1100", obs_be); end
      run_op(1'b0, 2'd1, 1'b0, 32'h0000_0102, 32'h0, 32'h80FF_7F01, 1, 0);
      n_checks++; if (obs_ld !== 32'h0000_80FF) begin n_errors++; $display("FAIL lhu_loadData: got %h want 000080ff", obs_ld); end
      run_op(1'b0, 2'd0, 1'b1, 32'h0000_0101, 32'h0, 32'h80FF_7F01, 1, 0);
      n_checks++; if (obs_ld !== 32'h0000_007F) begin n_errors++; $display("FAIL lb_pos_loadData: got %h want 0000007f", obs_ld); end
   endtask

   task automatic test_store_lanes();
      run_op(1'b1, 2'd0, 1'b0, 32'h0000_0201, 32'h0000_00AB, 32'h5555_5555, 2, 0);
      n_checks++; if (obs_be !== 4'b0010) begin n_errors++; $display("FAIL sb_be: got %b want 0010", obs_be); end
      n_checks++; if (obs_wdata !== 32'hABAB_ABAB) begin n_errors++; $display("FAIL sb_wdata: got %h want abababab", obs_wdata); end
      n_checks++; if (obs_addr !== 32'h0000_0200) begin n_errors++; $display("FAIL sb_addr: got %h want 00000200", obs_addr); end
      n_checks++; if (obs_we !== 1'b1) begin n_errors++; $display("FAIL sb_we: got %b want 1", obs_we); end
      n_checks++; if (obs_lv != 0) begin n_errors++; $display("FAIL sb_loadValid_cycles: got %0d want 0", obs_lv); end
      n_checks++; if (loadData !== 32'h0000_007F) begin n_errors++; $display("FAIL sb_loadData_kept: got %h want 0000007f", loadData); end
      run_op(1'b1, 2'd1, 1'b0, 32'h0000_0202, 32'h0000_1234, 32'h0, 1, 0);
      n_checks++; if (obs_be !== 4'b1100) begin n_errors++; $display("FAIL sh_be: got %b want 1100", obs_be); end
      n_checks++; if (obs_wdata !== 32'h1234_1234) begin n_errors++; $display("FAIL sh_wdata: got %h want 12341234", obs_wdata); end
      run_op(1'b1, 2'd3, 1'b0, 32'h0000_0204, 32'hCAFE_F00D, 32'h0, 1, 0);
      n_checks++; if (obs_be !== 4'b1111) begin n_errors++; $display("FAIL sw_be: got %b want 1111", obs_be); end
      n_checks++; if (obs_wdata !== 32'hCAFE_F00D) begin n_errors++; $display("FAIL sw_wdata: got %h want cafef00d", obs_wdata); end
      n_checks++; if (obs_addr !== 32'h0000_0204) begin n_errors++; $display("FAIL sw_addr: got %h want 00000204", obs_addr); end
   endtask

   task automatic test_misaligned();
      pipeMem_Valid = 1'b1; pipeMem_MemRead = 1'b1; pipeMem_MemWrite = 1'b0;
      pipeMem_MemSize = 2'd2; pipeMem_MemAddr = 32'h0000_0102;
      @(negedge clock);
      n_checks++; if (addrError !== 1'b1) begin n_errors++; $display("FAIL lw_mis_addrError: got %b want 1", addrError); end
      n_checks++; if (memStall !== 1'b0) begin n_errors++; $display("FAIL lw_mis_memStall: got %b want 0", memStall); end
      @(posedge clock); #1;
      pipeMem_MemRead = 1'b0; pipeMem_MemWrite = 1'b1; pipeMem_MemSize = 2'd1;
      pipeMem_MemAddr = 32'h0000_0203;
      @(negedge clock);
      n_checks++; if (dif.dmem_req !== 1'b0) begin n_errors++; $display("FAIL lw_mis_req: got %b want 0", dif.dmem_req); end
      n_checks++; if (addrError !== 1'b1) begin n_errors++; $display("FAIL sh_mis_addrError: got %b want 1", addrError); end
      @(posedge clock); #1;
      pipeMem_MemWrite = 1'b0; pipeMem_MemRead = 1'b1; pipeMem_MemSize = 2'd2;
      pipeMem_MemAddr = 32'h0000_0100; flush = 1'b1;
      @(negedge clock);
      n_checks++; if (dif.dmem_req !== 1'b0) begin n_errors++; $display("FAIL sh_mis_req: got %b want 0", dif.dmem_req); end
      n_checks++; if (memStall !== 1'b0) begin n_errors++; $display("FAIL idle_flush_memStall: got %b want 0", memStall); end
      @(posedge clock); #1;
      pipeMem_Valid = 1'b0; pipeMem_MemRead = 1'b0; flush = 1'b0;
      dif.dmem_ack = 1'b1; dif.dmem_rdata = 32'h9999_9999;
      @(negedge clock);
      n_checks++; if (dif.dmem_req !== 1'b0) begin n_errors++; $display("FAIL idle_flush_req: got %b want 0", dif.dmem_req); end
      @(posedge clock); #1;
      dif.dmem_ack = 1'b0;
      @(negedge clock);
      n_checks++; if (loadValid !== 1'b0 || dif.dmem_req !== 1'b0) begin n_errors++; $display("FAIL stray_ack: got lv=%b req=%b want 0 0", loadValid, dif.dmem_req); end
      @(posedge clock); #1;
   endtask

   task automatic test_flush_and_hold();
      int lv;
      lv = 0;
      pipeMem_Valid = 1'b1; pipeMem_MemRead = 1'b1; pipeMem_MemSize = 2'd2;
      pipeMem_MemAddr = 32'h0000_0300;
      @(negedge clock); if (loadValid) lv++;
      @(posedge clock); #1;
      n_checks++; if (dif.dmem_req !== 1'b1) begin n_errors++; $display("FAIL flush_req_open: got %b want 1", dif.dmem_req); end
      @(negedge clock); if (loadValid) lv++;
      @(posedge clock); #1;
      flush = 1'b1;
      @(negedge clock); if (loadValid) lv++;
      @(posedge clock); #1;
      flush = 1'b0; dif.dmem_ack = 1'b1; dif.dmem_rdata = 32'h1111_1111;
      @(negedge clock); if (loadValid) lv++;
      @(posedge clock); #1;
      dif.dmem_ack = 1'b0; pipeMem_Valid = 1'b0; pipeMem_MemRead = 1'b0;
      @(negedge clock); if (loadValid) lv++;
      n_checks++; if (lv != 0) begin n_errors++; $display("FAIL flush_loadValid_cycles: got %0d want 0", lv); end
      n_checks++; if (dif.dmem_req !== 1'b0 || memStall !== 1'b0) begin n_errors++; $display("FAIL flush_idle: got req=%b stall=%b want 0 0", dif.dmem_req, memStall); end
      @(posedge clock); #1;
      run_op(1'b0, 2'd2, 1'b0, 32'h0000_0500, 32'h0, 32'h0BAD_F00D, 1, 2);
      n_checks++; if (obs_lv != 3) begin n_errors++; $display("FAIL hold_loadValid_cycles: got %0d want 3", obs_lv); end
      n_checks++; if (obs_ld_stable !== 1'b1) begin n_errors++; $display("FAIL hold_loadData_stable: got %b want 1", obs_ld_stable); end
      n_checks++; if (obs_ld !== 32'h0BAD_F00D) begin n_errors++; $display("FAIL hold_loadData: got %h want 0badf00d", obs_ld); end
      n_checks++; if (obs_stalls != 2) begin n_errors++; $display("FAIL hold_stall_cycles: got %0d want 2", obs_stalls); end
   endtask

   task automatic test_reset_mid_txn();
      pipeMem_Valid = 1'b1; pipeMem_MemRead = 1'b1; pipeMem_MemSize = 2'd2;
      pipeMem_MemAddr = 32'h0000_0400;
      @(negedge clock);
      @(posedge clock); #1;
      n_checks++; if (dif.dmem_req !== 1'b1) begin n_errors++; $display("FAIL rst_req_open: got %b want 1", dif.dmem_req); end
      pipeMem_Valid = 1'b0; pipeMem_MemRead = 1'b0;
      reset_n = 1'b0;
      #1;
      n_checks++; if (dif.dmem_req !== 1'b0) begin n_errors++; $display("FAIL rst_req_drop: got %b want 0", dif.dmem_req); end
      n_checks++; if (memStall !== 1'b0) begin n_errors++; $display("FAIL rst_memStall: got %b want 0", memStall); end
      @(posedge clock); #1;
      reset_n = 1'b1;
      @(negedge clock);
      n_checks++; if (dif.dmem_req !== 1'b0 || loadData !== 32'h0) begin n_errors++; $display("FAIL rst_after: got req=%b ld=%h want 0 0", dif.dmem_req, loadData); end
      @(posedge clock); #1;
      run_op(1'b0, 2'd2, 1'b0, 32'h0000_0404, 32'h0, 32'h1234_5678, 2, 0);
      n_checks++; if (obs_timeout !== 1'b0) begin n_errors++; $display("FAIL rst_lw_timeout: got %b want 0", obs_timeout); end
      n_checks++; if (obs_stalls != 3) begin n_errors++; $display("FAIL rst_lw_stall_cycles: got %0d want 3", obs_stalls); end
      n_checks++; if (obs_lv != 1) begin n_errors++; $display("FAIL rst_lw_loadValid_cycles: got %0d want 1", obs_lv); end
      n_checks++; if (obs_ld !== 32'h1234_5678) begin n_errors++; $display("FAIL rst_lw_loadData: got %h want 12345678", obs_ld); end
   endtask

   initial begin
      n_checks = 0; n_errors = 0;
      reset_n = 1'b0;
      pipeMem_Valid = 1'b0; pipeMem_MemRead = 1'b0; pipeMem_MemWrite = 1'b0;
      pipeMem_MemSize = 2'd0; pipeMem_MemSigned = 1'b0; pipeMem_MemAddr = 32'h0;
      memData = 32'h0; pipeHold = 1'b0; flush = 1'b0;
      dif.dmem_ack = 1'b0; dif.dmem_rdata = 32'h0;
      test_reset();
      test_lw_latency();
      test_load_extend();
      test_store_lanes();
      test_misaligned();
      test_flush_and_hold();
      test_reset_mid_txn();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got time limit reached want run complete");
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire
